serial_addsub: RTL and testbench
================================

Name: serial_addsub

Overview:
Parametrised bit-serial adder/subtractor for the calculator datapath. It is the successor to the fixed 4-bit complement adder chain, with generic WIDTH, a start/busy/done handshake and four operation modes (add, two's-complement subtract, negate, ones' complement). It processes one bit per clock through a single full-adder slice with a carry register, and reports carry, signed overflow and zero flags.

Parameters:
WIDTH, 4, operand/result width in bits (legal range 2..32)
CNT_W, $clog2(WIDTH), width of internal bit-index counter (derived; not overridden)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-low reset (sampled on rising clk; 0 = reset)
start  input  1  request; sampled only in IDLE
op  input  2  00 ADD a+b; 01 SUB a-b; 10 NEG -a; 11 ONES ~a
a  input  WIDTH  operand A, latched on accepted start
b  input  WIDTH  operand B, latched on accepted start (ignored for NEG/ONES)
busy  output  1  high while in RUN
done  output  1  one-cycle pulse, result/flags valid
result  output  WIDTH  result, held until next accepted start completes
carry  output  1  carry out of MSB (SUB: 1 = no borrow)
overflow  output  1  signed two's-complement overflow
zero  output  1  result == 0

Behaviour:
- Reset (rst==0 at edge): state=IDLE; busy=0, done=0, result=0, carry=0, overflow=0, zero=0; internal regs cleared. Reset overrides any operation in progress; no done is produced for an aborted operation.
- States: IDLE, RUN, DONE.
- IDLE: at an edge with start==1, latch a, b, op; preset operand shift regs: A' = a (ADD/SUB) or ~a (NEG/ONES); B' = b (ADD), ~b (SUB), 0 (NEG/ONES); carry reg cin = 1 for SUB/NEG, else 0; bit index = 0; go to RUN. start==0: stay.
- RUN: each edge computes s = A'[i]^B'[i]^cin, cout = maj(A'[i],B'[i],cin); shifts s into result MSB-first-shift (result filled LSB first via right shift); cin <= cout; index++. Register the carry into bit WIDTH-1 for overflow.
- After the edge processing bit WIDTH-1: go to DONE; done=1; carry = final cout; overflow = carry_into_MSB ^ carry_out_of_MSB (ADD/SUB/NEG), forced 0 for ONES; carry forced 0 for ONES; zero = (final result==0).
- Latency: done asserts exactly WIDTH clock edges after the accepting edge, high for one cycle. DONE -> IDLE unconditionally on next edge.
- start in RUN or DONE is ignored (not queued); a, b, op changes after acceptance have no effect.
- busy=1 exactly in RUN (WIDTH cycles). done and busy are never high together.
- result/flags change only on the DONE transition and reset; they hold across IDLE. Intermediate shift contents are internal, not visible on result.
- Back-to-back: start held high continuously yields one operation every WIDTH+2 cycles (accept, WIDTH runs incl. DONE entry, DONE->IDLE).
- NEG of most-negative value (10..0) returns 10..0 with overflow=1. NEG of 0 returns 0, carry=1, overflow=0.

Test Plan:
- WIDTH=4, ADD a=0101 b=0011 -> after 4 edges done=1, result=1000, carry=0, overflow=1, zero=0; busy high 4 cycles.
- WIDTH=4, SUB a=0011 b=0101 -> result=1110, carry=0, overflow=0; then SUB a=0101 b=0101 -> result=0000, carry=1, zero=1.
- WIDTH=4, NEG a=1000 -> result=1000, overflow=1; ONES a=1010 (b=1111) -> result=0101, carry=0, overflow=0.
- WIDTH=8, ADD a=0xFF b=0x01 -> result=0x00, carry=1, zero=1, overflow=0; done exactly 8 edges after accept.
- Start pulsed again at cycles 2 and the DONE cycle with different operands -> ignored; only one done; result matches first operands; start held continuously -> done every WIDTH+2 cycles.
- Reset low at bit 2 of a WIDTH=4 ADD -> next cycle all outputs 0, state IDLE, no done; new start afterwards produces correct result.

Source files
------------

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder slice and a carry register, LSB first.
// Supports add, two's-complement subtract, negate and ones' complement, with carry/overflow/zero flags.
module serial_addsub #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_NEG  = 2'b10;
  localparam logic [1:0] OP_ONES = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cin_q, cin_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;

  logic               s_bit, c_bit;
  logic [WIDTH-1:0]   sum_nx;

  always_comb begin
    s_bit  = a_sh_q[0] ^ b_sh_q[0] ^ cin_q;
    c_bit  = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & cin_q) | (b_sh_q[0] & cin_q);
    sum_nx = {s_bit, sum_q[WIDTH-1:1]};

    state_d  = state_q;
    op_d     = op_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_d    = sum_q;
    cin_d    = cin_q;
    idx_d    = idx_q;
    result_d = result_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          op_d    = op;
          a_sh_d  = (op == OP_NEG || op == OP_ONES) ? ~a : a;
          case (op)
            OP_ADD:  b_sh_d = b;
            OP_SUB:  b_sh_d = ~b;
            default: b_sh_d = '0;
          endcase
          cin_d = (op == OP_SUB || op == OP_NEG);
          idx_d = '0;
          sum_d = '0;
        end
      end
      S_RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        sum_d  = sum_nx;
        cin_d  = c_bit;
        idx_d  = idx_q + CNT_W'(1);
        // On the MSB, cin_q is the carry into the sign bit, c_bit the carry out of it.
        if (idx_q == CNT_W'(WIDTH - 1)) begin
          state_d  = S_DONE;
          result_d = sum_nx;
          carry_d  = (op_q == OP_ONES) ? 1'b0 : c_bit;
          ovf_d    = (op_q == OP_ONES) ? 1'b0 : (cin_q ^ c_bit);
          zero_d   = (sum_nx == '0);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_q    <= '0;
      cin_q    <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_q    <= sum_d;
      cin_q    <= cin_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign result   = result_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: WIDTH=4 and WIDTH=8 instances, directed and random operations
// compared against an arithmetic reference model.
module tb_serial_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       s4, s8;
  logic [1:0] op;
  logic [3:0] a4, b4;
  logic [7:0] a8, b8;

  logic       busy4, done4, c4, v4, z4;
  logic [3:0] res4;
  logic       busy8, done8, c8, v8, z8;
  logic [7:0] res8;

  int checks   = 0;
  int failures = 0;

  serial_addsub #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(s4), .op(op), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .result(res4), .carry(c4), .overflow(v4), .zero(z4)
  );

  serial_addsub #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(s8), .op(op), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(res8), .carry(c8), .overflow(v8), .zero(z8)
  );

  // Reference: plain integer arithmetic on w-bit values.
  function automatic void model(input int w, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic c, output logic v, output logic z);
    longint unsigned mask, aa, bb, full, rr;
    logic sa, sb, sr;
    mask = (64'd1 << w) - 64'd1;
    aa   = {32'd0, a} & mask;
    bb   = {32'd0, b} & mask;
    case (o)
      2'b00:   full = aa + bb;
      2'b01:   full = aa + ((~bb) & mask) + 64'd1;
      2'b10:   full = ((~aa) & mask) + 64'd1;
      default: full = (~aa) & mask;
    endcase
    rr = full & mask;
    sa = aa[w-1];
    sb = bb[w-1];
    sr = rr[w-1];
    r  = rr[31:0];
    c  = (o == 2'b11) ? 1'b0 : full[w];
    case (o)
      2'b00:   v = (sa == sb) && (sr != sa);
      2'b01:   v = (sa != sb) && (sr != sa);
      2'b10:   v = (aa == (64'd1 << (w - 1)));
      default: v = 1'b0;
    endcase
    z = (rr == 64'd0);
  endfunction

  // Drives one operation into the selected instance and returns what it produced at done.
  task automatic run_op(input bit w8, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic c, output logic v, output logic z,
                        output int lat, output int busy_n, output bit both);
    @(negedge clk);
    op = o;
    if (w8) begin a8 = a[7:0]; b8 = b[7:0]; s8 = 1'b1; end
    else    begin a4 = a[3:0]; b4 = b[3:0]; s4 = 1'b1; end
    @(negedge clk);
    s4 = 1'b0; s8 = 1'b0;
    lat = -1; busy_n = 0; both = 1'b0;
    for (int k = 0; k < 64; k++) begin
      if (w8 ? (busy8 && done8) : (busy4 && done4)) both = 1'b1;
      if (w8 ? done8 : done4) begin lat = k; break; end
      if (w8 ? busy8 : busy4) busy_n++;
      @(negedge clk);
    end
    r = w8 ? {24'd0, res8} : {28'd0, res4};
    c = w8 ? c8 : c4;
    v = w8 ? v8 : v4;
    z = w8 ? z8 : z4;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; s4 = 1'b0; s8 = 1'b0; op = 2'b00;
    a4 = '0; b4 = '0; a8 = '0; b8 = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy4, done4, c4, v4, z4, res4} !== 9'd0) begin
      failures++; $display("FAIL reset_w4 got=%b want=0", {busy4, done4, c4, v4, z4, res4});
    end
    checks++;
    if ({busy8, done8, c8, v8, z8, res8} !== 13'd0) begin
      failures++; $display("FAIL reset_w8 got=%b want=0", {busy8, done8, c8, v8, z8, res8});
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add4();
    logic [31:0] r; logic c, v, z; int lat, bn; bit both;
    run_op(1'b0, 2'b00, 32'h5, 32'h3, r, c, v, z, lat, bn, both);
    checks++;
    if ({r, c, v, z} !== {32'h8, 1'b0, 1'b1, 1'b0}) begin
      failures++; $display("FAIL add4 got r=%h c=%b v=%b z=%b want r=8 c=0 v=1 z=0", r, c, v, z);
    end
    checks++;
    if (lat !== 4 || bn !== 4 || both !== 1'b0) begin
      failures++; $display("FAIL add4_timing got lat=%0d busy=%0d both=%b want 4 4 0", lat, bn, both);
    end
  endtask

  task automatic test_sub4();
    logic [31:0] r; logic c, v, z; int lat, bn; bit both;
    run_op(1'b0, 2'b01, 32'h3, 32'h5, r, c, v, z, lat, bn, both);
    checks++;
    if ({r, c, v, z} !== {32'hE, 1'b0, 1'b0, 1'b0}) begin
      failures++; $display("FAIL sub4_neg got r=%h c=%b v=%b z=%b want r=e c=0 v=0 z=0", r, c, v, z);
    end
    run_op(1'b0, 2'b01, 32'h5, 32'h5, r, c, v, z, lat, bn, both);
    checks++;
    if ({r, c, v, z} !== {32'h0, 1'b1, 1'b0, 1'b1}) begin
      failures++; $display("FAIL sub4_zero got r=%h c=%b v=%b z=%b want r=0 c=1 v=0 z=1", r, c, v, z);
    end
  endtask

  task automatic test_neg_ones4();
    logic [31:0] r; logic c, v, z; int lat, bn; bit both;
    run_op(1'b0, 2'b10, 32'h8, 32'h0, r, c, v, z, lat, bn, both);
    checks++;
    if ({r, c, v, z} !== {32'h8, 1'b0, 1'b1, 1'b0}) begin
      failures++; $display("FAIL neg4_minval got r=%h c=%b v=%b z=%b want r=8 c=0 v=1 z=0", r, c, v, z);
    end
    run_op(1'b0, 2'b10, 32'h0, 32'h0, r, c, v, z, lat, bn, both);
    checks++;
    if ({r, c, v, z} !== {32'h0, 1'b1, 1'b0, 1'b1}) begin
      failures++; $display("FAIL neg4_zero got r=%h c=%b v=%b z=%b want r=0 c=1 v=0 z=1", r, c, v, z);
    end
    run_op(1'b0, 2'b11, 32'hA, 32'hF, r, c, v, z, lat, bn, both);
    checks++;
    if ({r, c, v, z} !== {32'h5, 1'b0, 1'b0, 1'b0}) begin
      failures++; $display("FAIL ones4 got r=%h c=%b v=%b z=%b want r=5 c=0 v=0 z=0", r, c, v, z);
    end
  endtask

  task automatic test_add8();
    logic [31:0] r; logic c, v, z; int lat, bn; bit both;
    run_op(1'b1, 2'b00, 32'hFF, 32'h01, r, c, v, z, lat, bn, both);
    checks++;
    if ({r, c, v, z} !== {32'h0, 1'b1, 1'b0, 1'b1}) begin
      failures++; $display("FAIL add8_wrap got r=%h c=%b v=%b z=%b want r=0 c=1 v=0 z=1", r, c, v, z);
    end
    checks++;
    if (lat !== 8 || bn !== 8 || both !== 1'b0) begin
      failures++; $display("FAIL add8_timing got lat=%0d busy=%0d both=%b want 8 8 0", lat, bn, both);
    end
  endtask

  task automatic test_random();
    logic [31:0] r, er, a, b; logic c, v, z, ec, ev, ez; int lat, bn, w; bit both, w8; logic [1:0] o;
    for (int i = 0; i < 40; i++) begin
      w8 = $urandom_range(1, 0);
      w  = w8 ? 8 : 4;
      o  = 2'($urandom_range(3, 0));
      a  = $urandom;
      b  = $urandom;
      model(w, o, a, b, er, ec, ev, ez);
      run_op(w8, o, a, b, r, c, v, z, lat, bn, both);
      checks++;
      if ({r, c, v, z} !== {er, ec, ev, ez}) begin
        failures++;
        $display("FAIL rand_w%0d op=%0d a=%h b=%h got r=%h c=%b v=%b z=%b want r=%h c=%b v=%b z=%b",
                 w, o, a, b, r, c, v, z, er, ec, ev, ez);
      end
      checks++;
      if (lat !== w || bn !== w || both !== 1'b0) begin
        failures++; $display("FAIL rand_timing_w%0d got lat=%0d busy=%0d both=%b want %0d %0d 0", w, lat, bn, both, w, w);
      end
    end
  endtask

  task automatic test_ignore_start();
    int dones;
    @(negedge clk);
    op = 2'b00; a4 = 4'd3; b4 = 4'd4; s4 = 1'b1;
    @(negedge clk);
    s4 = 1'b0; op = 2'b01; a4 = 4'd7; b4 = 4'd7;
    dones = 0;
    for (int k = 0; k < 14; k++) begin
      if (done4) begin dones++; s4 = 1'b1; a4 = 4'd9; b4 = 4'd2; end
      else if (k == 1) s4 = 1'b1;
      else s4 = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (dones !== 1) begin
      failures++; $display("FAIL ignore_start_dones got=%0d want=1", dones);
    end
    checks++;
    if (res4 !== 4'd7 || busy4 !== 1'b0) begin
      failures++; $display("FAIL ignore_start_result got r=%h busy=%b want r=7 busy=0", res4, busy4);
    end
  endtask

  task automatic test_back_to_back();
    int times[$];
    logic [31:0] er; logic ec, ev, ez; bit bad, both;
    model(4, 2'b00, 32'h6, 32'h7, er, ec, ev, ez);
    bad = 1'b0; both = 1'b0;
    @(negedge clk);
    op = 2'b00; a4 = 4'd6; b4 = 4'd7; s4 = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 40; k++) begin
      if (busy4 && done4) both = 1'b1;
      if (done4) begin
        times.push_back(k);
        if ({res4, c4, v4, z4} !== {er[3:0], ec, ev, ez}) bad = 1'b1;
      end
      @(negedge clk);
    end
    s4 = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (times.size() !== 6 || bad || both) begin
      failures++; $display("FAIL b2b_count got n=%0d badres=%b both=%b want n=6 0 0", times.size(), bad, both);
    end
    for (int i = 1; i < times.size(); i++) begin
      checks++;
      if (times[i] - times[i-1] !== 6) begin
        failures++; $display("FAIL b2b_period got=%0d want=6", times[i] - times[i-1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r; logic c, v, z; int lat, bn, dones; bit both;
    run_op(1'b0, 2'b00, 32'h5, 32'h3, r, c, v, z, lat, bn, both);
    @(negedge clk);
    op = 2'b00; a4 = 4'd6; b4 = 4'd1; s4 = 1'b1;
    @(negedge clk);
    s4 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy4, done4, c4, v4, z4, res4} !== 9'd0) begin
      failures++; $display("FAIL reset_mid_outputs got=%b want=0", {busy4, done4, c4, v4, z4, res4});
    end
    rst = 1'b1;
    dones = 0;
    for (int k = 0; k < 8; k++) begin
      if (done4 || busy4) dones++;
      @(negedge clk);
    end
    checks++;
    if (dones !== 0) begin
      failures++; $display("FAIL reset_mid_abort got activity=%0d want=0", dones);
    end
    run_op(1'b0, 2'b00, 32'h2, 32'h3, r, c, v, z, lat, bn, both);
    checks++;
    if ({r, c, v, z} !== {32'h5, 1'b0, 1'b0, 1'b0} || lat !== 4) begin
      failures++; $display("FAIL reset_mid_after got r=%h c=%b v=%b z=%b lat=%0d want r=5 c=0 v=0 z=0 lat=4", r, c, v, z, lat);
    end
  endtask

  initial begin
    test_reset();
    test_add4();
    test_sub4();
    test_neg_ones4();
    test_add8();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
